// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the command master.
// Also provides the request size/alignment legality helper.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  // Only byte/half/word sizes are supported, each naturally aligned.
  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = (addr_lo[0] == 1'b0);
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_lite_cmd_master_if.sv
// Request/response port plus AHB-Lite bus signals of the command master.
// The master modport is the initiator's view; slave is the environment's view.
interface ahb_lite_cmd_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    input  HRDATA, HREADY, HRESP,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HBURST, HPROT, HMASTLOCK
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    output HRDATA, HREADY, HRESP,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HBURST, HPROT, HMASTLOCK
  );

endinterface

// File: rtl/ahb_lite_cmd_master_req_checker.sv
// Combinational legality check of a request's size and low address bits.
module ahb_req_checker
  import ahb_lite_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic       ok
);

  // Legal when the size is supported and the address is naturally aligned.
  always_comb begin
    ok = size_aligned(size, addr_lo);
  end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// Single-outstanding AHB-Lite initiator: one request becomes one SINGLE transfer.
// Optional HREADY-stall timeout enabled by defining AHB_CMD_MASTER_TIMEOUT_EN.
module ahb_lite_cmd_master
  import ahb_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_lite_cmd_master_if.master bus
);

  state_e      state_r, state_s;
  logic [1:0]  htrans_r, htrans_s;
  logic [31:0] haddr_r, haddr_s;
  logic [2:0]  hsize_r, hsize_s;
  logic        hwrite_r, hwrite_s;
  logic [31:0] hwdata_r, hwdata_s;
  logic [31:0] wdata_r, wdata_s;
  logic        req_ready_r, req_ready_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic        rsp_err_r, rsp_err_s;
  logic [31:0] rsp_rdata_r, rsp_rdata_s;
  logic        rsp_timeout_r, rsp_timeout_s;
  logic        req_ok_s;

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             stall_s;
  logic             timeout_hit_s;
`else
  logic             unused_timeout_cfg_s;
  always_comb begin
    unused_timeout_cfg_s = (TIMEOUT_CYCLES != 32'd0);
  end
`endif

  ahb_req_checker u_req_checker (
    .size    (bus.req_size),
    .addr_lo (bus.req_addr[1:0]),
    .ok      (req_ok_s)
  );

  // Next-state and next-output computation; response outputs default to an idle pulse.
  always_comb begin
    state_s       = state_r;
    htrans_s      = htrans_r;
    haddr_s       = haddr_r;
    hsize_s       = hsize_r;
    hwrite_s      = hwrite_r;
    hwdata_s      = hwdata_r;
    wdata_s       = wdata_r;
    req_ready_s   = req_ready_r;
    rsp_valid_s   = 1'b0;
    rsp_err_s     = 1'b0;
    rsp_rdata_s   = 32'h0000_0000;
    rsp_timeout_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_r) begin
          if (req_ok_s) begin
            state_s     = ST_ADDR;
            htrans_s    = HTRANS_NONSEQ;
            haddr_s     = bus.req_addr;
            hsize_s     = bus.req_size;
            hwrite_s    = bus.req_write;
            wdata_s     = bus.req_write ? bus.req_wdata : 32'h0000_0000;
            req_ready_s = 1'b0;
          end else begin
            // Rejected locally: answer immediately without touching the bus.
            rsp_valid_s = 1'b1;
            rsp_err_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) begin
          state_s  = ST_DATA;
          htrans_s = HTRANS_IDLE;
          hwdata_s = wdata_r;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (bus.HREADY) begin
          state_s     = ST_IDLE;
          req_ready_s = 1'b1;
          rsp_valid_s = 1'b1;
          rsp_err_s   = bus.HRESP;
          rsp_rdata_s = (!hwrite_r && !bus.HRESP) ? bus.HRDATA : 32'h0000_0000;
        end else if (bus.HRESP) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_ERR: begin
        if (bus.HREADY) begin
          state_s     = ST_IDLE;
          req_ready_s = 1'b1;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
        end else begin
          state_s = ST_ERR;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        htrans_s    = HTRANS_IDLE;
        req_ready_s = 1'b1;
      end
    endcase

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    stall_s       = ((state_r == ST_DATA) || (state_r == ST_ERR)) && !bus.HREADY;
    timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    if (stall_s && timeout_hit_s) begin
      state_s       = ST_IDLE;
      htrans_s      = HTRANS_IDLE;
      req_ready_s   = 1'b1;
      rsp_valid_s   = 1'b1;
      rsp_err_s     = 1'b1;
      rsp_rdata_s   = 32'h0000_0000;
      rsp_timeout_s = 1'b1;
      cnt_s         = '0;
    end else if (state_s != state_r) begin
      cnt_s = '0;
    end else if (stall_s) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
`endif
  end

  // State and registered bus/response outputs with asynchronous reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r       <= ST_IDLE;
      htrans_r      <= HTRANS_IDLE;
      haddr_r       <= 32'h0000_0000;
      hsize_r       <= 3'b000;
      hwrite_r      <= 1'b0;
      hwdata_r      <= 32'h0000_0000;
      wdata_r       <= 32'h0000_0000;
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_rdata_r   <= 32'h0000_0000;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      htrans_r      <= htrans_s;
      haddr_r       <= haddr_s;
      hsize_r       <= hsize_s;
      hwrite_r      <= hwrite_s;
      hwdata_r      <= hwdata_s;
      wdata_r       <= wdata_s;
      req_ready_r   <= req_ready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_err_r     <= rsp_err_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
  // Stall counter for the HREADY timeout.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_s;
    end
  end
`endif

  assign bus.HTRANS      = htrans_r;
  assign bus.HADDR       = haddr_r;
  assign bus.HSIZE       = hsize_r;
  assign bus.HWRITE      = hwrite_r;
  assign bus.HWDATA      = hwdata_r;
  assign bus.HBURST      = HBURST_SINGLE;
  assign bus.HPROT       = HPROT_DEFAULT;
  assign bus.HMASTLOCK   = 1'b0;
  assign bus.req_ready   = req_ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_timeout = rsp_timeout_r;

endmodule
